axis_to_dcmac_seg: RTL

//  Parametrised AXI-Stream to DCMAC segmented-TX converter, successor to the fixed 2-segment converter.

---
 rtl/axis_to_dcmac_seg.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_to_dcmac_seg.sv
// rtl/axis_to_dcmac_seg.sv - AXI-Stream to DCMAC segmented TX converter with skid buffer and stats
//
// Purpose:
//   Splits each DW-bit AXI-Stream beat into NSEG segments of SW bits and derives the
//   per-segment ena/sop/eop/mty/err sideband expected by the DCMAC TX port. Beats pass
//   through a 2-entry skid buffer. Malformed tkeep patterns are flagged, and upstream or
//   tkeep errors are folded into the err bit of the packet's eop segment. Packets
//   handed to the MAC are counted.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   axis_in_*                   upstream AXI-Stream slave (tdata/tkeep/tlast/tuser/tvalid/tready)
//   tx_axis_tdata               segment i = [i*SW +: SW]
//   tx_axis_tuser_ena/sop/eop/err  one bit per segment
//   tx_axis_tuser_mty           segment i = [i*MTYW +: MTYW], count of empty bytes
//   tx_axis_tvalid/tready       handshake towards DCMAC
//   clear_stats                 synchronous clear of pkt_count and keep_error
//   pkt_count                   eop beats accepted by DCMAC, wraps
//   keep_error                  sticky malformed-tkeep flag

module axis_to_dcmac_seg #(
  parameter  int NSEG = 2,
  parameter  int SW   = 128,
  localparam int DW   = NSEG * SW,
  localparam int MTYW = $clog2(SW / 8)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DW-1:0]          axis_in_tdata,
  input  logic [DW/8-1:0]        axis_in_tkeep,
  input  logic                   axis_in_tlast,
  input  logic                   axis_in_tuser,
  input  logic                   axis_in_tvalid,
  output logic                   axis_in_tready,
  output logic [NSEG*SW-1:0]     tx_axis_tdata,
  output logic [NSEG-1:0]        tx_axis_tuser_ena,
  output logic [NSEG-1:0]        tx_axis_tuser_sop,
  output logic [NSEG-1:0]        tx_axis_tuser_eop,
  output logic [NSEG-1:0]        tx_axis_tuser_err,
  output logic [NSEG*MTYW-1:0]   tx_axis_tuser_mty,
  output logic                   tx_axis_tvalid,
  input  logic                   tx_axis_tready,
  input  logic                   clear_stats,
  output logic [31:0]            pkt_count,
  output logic                   keep_error
);

  localparam int KW = SW / 8;  // bytes per segment
  localparam int BW = DW / 8;  // bytes per beat

  // Skid buffer storage: two entries, ping-pong read/write pointers
  logic [1:0]            r_count;
  logic                  r_wr;
  logic                  r_rd;
  logic [DW-1:0]         r_data [2];
  logic [NSEG-1:0]       r_ena  [2];
  logic [NSEG-1:0]       r_sop  [2];
  logic [NSEG-1:0]       r_eop  [2];
  logic [NSEG-1:0]       r_err  [2];
  logic [NSEG*MTYW-1:0]  r_mty  [2];

  // Packet tracking and statistics
  logic                  r_in_pkt;
  logic                  r_pkt_bad;
  logic                  r_tuser;
  logic                  r_keep_error;
  logic [31:0]           r_pkt_count;

  logic                  w_accept;
  logic                  w_xfer;
  logic [BW-1:0]         w_keep_inc;
  logic                  w_contig;
  logic                  w_all_ones;
  logic                  w_none;
  logic                  w_malformed;
  logic                  w_err_bit;
  logic [NSEG-1:0]       w_present;
  logic [NSEG-1:0]       w_eop_sel;
  logic [MTYW-1:0]       w_zero_cnt [NSEG];
  logic [NSEG-1:0]       w_ena;
  logic [NSEG-1:0]       w_sop;
  logic [NSEG-1:0]       w_eop;
  logic [NSEG-1:0]       w_err;
  logic [NSEG*MTYW-1:0]  w_mty;

  // Ready depends only on buffer occupancy, never on tx_axis_tready, so there is
  // no combinational path from the MAC back to the upstream source.
  assign axis_in_tready = !reset && (r_count != 2'd2);
  assign w_accept       = axis_in_tvalid && axis_in_tready;
  assign tx_axis_tvalid = (r_count != 2'd0);
  assign w_xfer         = tx_axis_tvalid && tx_axis_tready;

  // A keep vector is contiguous from byte 0 exactly when it has the form 2^n-1,
  // i.e. adding one clears every set bit.
  assign w_keep_inc  = axis_in_tkeep + {{(BW-1){1'b0}}, 1'b1};
  assign w_contig    = ((axis_in_tkeep & w_keep_inc) == '0);
  assign w_all_ones  = &axis_in_tkeep;
  assign w_none      = ~|axis_in_tkeep;
  assign w_malformed = axis_in_tlast ? (w_none || !w_contig) : !w_all_ones;
  assign w_err_bit   = axis_in_tuser | r_tuser | r_pkt_bad | w_malformed;

  always_comb begin
    w_present = '0;
    w_eop_sel = '0;
    for (int i = 0; i < NSEG; i++) begin
      w_present[i]  = |axis_in_tkeep[i*KW +: KW];
      w_zero_cnt[i] = '0;
      // Cannot overflow for a segment that has at least one byte present;
      // the all-empty case is overridden below.
      for (int b = 0; b < KW; b++) begin
        w_zero_cnt[i] = w_zero_cnt[i] + MTYW'(!axis_in_tkeep[i*KW + b]);
      end
      // Last assignment wins: eop lands on the highest present segment
      if (w_present[i]) begin
        w_eop_sel    = '0;
        w_eop_sel[i] = 1'b1;
      end
    end
    // An all-zero last beat still needs an eop to close the packet
    if (w_none) begin
      w_eop_sel[0] = 1'b1;
    end
  end

  always_comb begin
    w_ena    = '1;
    w_sop    = '0;
    w_sop[0] = !r_in_pkt;
    w_eop    = '0;
    w_err    = '0;
    w_mty    = '0;
    if (axis_in_tlast) begin
      w_ena = w_present;
      if (w_none) begin
        w_ena[0] = 1'b1;
      end
      w_eop = w_eop_sel;
      for (int i = 0; i < NSEG; i++) begin
        if (w_eop_sel[i]) begin
          w_err[i]              = w_err_bit;
          w_mty[i*MTYW +: MTYW] = w_none ? '1 : w_zero_cnt[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count      <= 2'd0;
      r_wr         <= 1'b0;
      r_rd         <= 1'b0;
      r_in_pkt     <= 1'b0;
      r_pkt_bad    <= 1'b0;
      r_tuser      <= 1'b0;
      r_keep_error <= 1'b0;
      r_pkt_count  <= 32'd0;
      for (int e = 0; e < 2; e++) begin
        r_data[e] <= '0;
        r_ena[e]  <= '0;
        r_sop[e]  <= '0;
        r_eop[e]  <= '0;
        r_err[e]  <= '0;
        r_mty[e]  <= '0;
      end
    end else begin
      if (w_accept) begin
        r_data[r_wr] <= axis_in_tdata;
        r_ena[r_wr]  <= w_ena;
        r_sop[r_wr]  <= w_sop;
        r_eop[r_wr]  <= w_eop;
        r_err[r_wr]  <= w_err;
        r_mty[r_wr]  <= w_mty;
        r_wr         <= ~r_wr;
        r_in_pkt     <= !axis_in_tlast;
        r_pkt_bad    <= axis_in_tlast ? 1'b0 : (r_pkt_bad | w_malformed);
        r_tuser      <= axis_in_tlast ? 1'b0 : (r_tuser | axis_in_tuser);
      end

      if (w_xfer) begin
        r_rd <= ~r_rd;
      end

      case ({w_accept, w_xfer})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (clear_stats) begin
        r_keep_error <= 1'b0;
      end else if (w_accept && w_malformed) begin
        r_keep_error <= 1'b1;
      end

      if (clear_stats) begin
        r_pkt_count <= 32'd0;
      end else if (w_xfer && (|r_eop[r_rd])) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign tx_axis_tdata     = r_data[r_rd];
  assign tx_axis_tuser_ena = r_ena[r_rd];
  assign tx_axis_tuser_sop = r_sop[r_rd];
  assign tx_axis_tuser_eop = r_eop[r_rd];
  assign tx_axis_tuser_err = r_err[r_rd];
  assign tx_axis_tuser_mty = r_mty[r_rd];
  assign pkt_count         = r_pkt_count;
  assign keep_error        = r_keep_error;

endmodule
